frame_rotate_ctrl: RTL and testbench
====================================

Name: frame_rotate_ctrl

Overview:
- Sequences one square frame through the shared single-port image SRAM: loads a raster stream into the SRAM, then drains it in one of four orientations.
- Owns the SRAM port, the input and output valid/ready handshakes, and the frame-level start/busy/done control.
- Sits between the pixel source and the downstream consumer, and replaces direct mode-pin driving of the SRAM.

Parameters:
- N, 512: frame side in pixels; the frame is N x N; must be a power of two, 4 or more.
- CW, 9: coordinate width, equal to log2(N).
- DW, 8: pixel width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle frame start request; accepted only in IDLE
- op  in  2  orientation, latched on accepted start: 0 identity, 1 rotate CCW, 2 rotate CW, 3 rotate 180
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse after the last output pixel is accepted
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel ready
- s_data  in  DW  input pixel, raster order (row y, column x ascending)
- m_valid  out  1  output pixel valid
- m_ready  in  1  output pixel ready
- m_data  out  DW  output pixel
- m_sol  out  1  qualifies m_valid: first pixel of an output row (x==0)
- m_last  out  1  qualifies m_valid: final pixel of the frame
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  2*CW  SRAM address {row, col}
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data, valid one cycle after a read (sram_en=1, sram_we=0)

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values: state=IDLE; all outputs 0; counters, FIFO and in-flight flag cleared.
- States:
  - IDLE: start=1 latches op, clears x/y, goes to LOAD.
  - LOAD: s_ready=1. On each s_valid&&s_ready: sram_en=1, sram_we=1, addr={y,x}, wdata=s_data, then advance x/y. The write of pixel (N-1,N-1) goes to DRAIN with x/y cleared.
  - DRAIN: s_ready=0. Issues reads in output raster order (y, x). The cycle that issues the last read is followed by a wait for the FIFO to empty. done pulses in the cycle after the handshake with m_last=1, and the state returns to IDLE.
- Counter advance: if x==N-1 then x=0 and y=y+1, else x=x+1. All address arithmetic is CW bits, with N-1-v computed as bitwise ~v.
- Drain address map for output (y,x):
  - op0: {y, x}
  - op1: {x, N-1-y}
  - op2: {N-1-x, y}
  - op3: {N-1-y, N-1-x}
- Output buffering:
  - 2-entry FIFO feeds m_*. A 1-bit inflight flag marks a read issued in the previous cycle.
  - pop = m_valid&&m_ready.
  - Read issued in a cycle iff reads remain and (count + inflight - pop) < 2.
  - Returning data is pushed the cycle after issue, together with its sol/last tags computed at issue.
  - Sustains 1 pixel/cycle when m_ready is held 1.
  - m_valid = (count != 0). m_data/m_sol/m_last come from the FIFO head and stay stable while m_valid&&!m_ready.
- Latency: first m_valid 2 cycles after DRAIN entry.
- start while busy: ignored, no error.
- s_valid outside LOAD: ignored, because s_ready=0.
- Stalls: s_valid low in LOAD, or m_ready low in DRAIN, pause progress indefinitely with no loss and no duplication.
- rst mid-frame: immediate return to IDLE; FIFO discarded; no done pulse.
- sram_en=0 in any cycle with no write and no read issued.
- sram_addr/sram_wdata are don't-care when sram_en=0, and are driven 0 in that case.

Decomposition:
- Shared package `img_pkg`:
  - N, CW, DW defaults
  - state encoding IDLE/LOAD/DRAIN
  - op codes OP_ID/OP_CCW/OP_CW/OP_R180
- Sub-module `xy_scan`:
  - x/y counter with clear, advance, and is-last/is-sol flags.
  - Two instances: load scan and drain issue scan.
- Address map and output FIFO stay inline.

Test Plan:
- Run the bench with N=4.
- Identity, full throughput: load pixels 0..15 with s_valid=1, op=0, m_ready=1 -> output 0..15 at 1/cycle; m_sol on 0,4,8,12; m_last on 15; done one cycle after 15 is accepted; busy falls.
- CCW, op=1, pixels 0..15 -> output row 0 is 3,7,11,15; full sequence 3,7,11,15,2,6,10,14,1,5,9,13,0,4,8,12.
- CW, op=2 -> first row 12,8,4,0. Rot180, op=3 -> 15,14,…,0.
- Backpressure: toggle m_ready randomly (~50%) and gap s_valid -> identical ordered output; no drops or duplicates; m_data stable while stalled; at most 2 reads outstanding past the FIFO.
- Control corners:
  - start pulsed during LOAD -> ignored; op change mid-frame has no effect.
  - rst asserted at the 6th output pixel -> all outputs 0 next edge; a new frame then runs correctly.
  - Two back-to-back frames with start in the cycle after done -> both correct.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image-path blocks: frame geometry defaults,
// controller state encoding and orientation codes.
package img_pkg;

    localparam int IMG_N  = 512;
    localparam int IMG_CW = 9;
    localparam int IMG_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ID   = 2'd0,
        OP_CCW  = 2'd1,
        OP_CW   = 2'd2,
        OP_R180 = 2'd3
    } op_t;

endpackage

// File: rtl/frame_rotate_ctrl_if.sv
// Frame-level control, pixel stream handshakes and SRAM port of the
// rotation controller; slave is the controller side.
interface frame_rotate_ctrl_if #(
    parameter int CW = 9,
    parameter int DW = 8
);
    logic          start;
    logic [1:0]    op;
    logic          busy;
    logic          done;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sol;
    logic          m_last;
    logic          sram_en;
    logic          sram_we;
    logic [2*CW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    modport slave (
        input  start, op, s_valid, s_data, m_ready, sram_rdata,
        output busy, done, s_ready, m_valid, m_data, m_sol, m_last,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output start, op, s_valid, s_data, m_ready, sram_rdata,
        input  busy, done, s_ready, m_valid, m_data, m_sol, m_last,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/xy_scan.sv
// Raster x/y scan counter over an N x N frame with start-of-row and
// end-of-frame flags for the current position.
module xy_scan
    import img_pkg::*;
#(
    parameter int N  = IMG_N,
    parameter int CW = IMG_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_sol,
    output logic          o_last
);
    localparam logic [CW-1:0] MAXC = CW'(N - 1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (r_x == MAXC) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_sol  = (r_x == '0);
    assign o_last = (r_x == MAXC) && (r_y == MAXC);
endmodule

// File: rtl/frame_rotate_ctrl.sv
// Loads one N x N frame into the shared SRAM in raster order, then drains it
// in the latched orientation through a 2-entry output FIFO.
module frame_rotate_ctrl
    import img_pkg::*;
#(
    parameter int N  = IMG_N,
    parameter int CW = IMG_CW,
    parameter int DW = IMG_DW
) (
    input  logic clk,
    input  logic rst,
    frame_rotate_ctrl_if.slave bus
);
    state_t          r_state;
    op_t             r_op;
    logic            r_rd_pend;
    logic            r_infl;
    logic            r_inf_sol;
    logic            r_inf_last;
    logic            r_done;
    logic [DW+1:0]   r_fifo [2];
    logic            r_wp;
    logic            r_rp;
    logic [1:0]      r_cnt;

    logic [CW-1:0]   w_lx, w_ly, w_dx, w_dy;
    logic            w_ld_sol, w_ld_last, w_dr_sol, w_dr_last;
    logic            w_unused_ld_sol;
    logic            w_start, w_wr, w_rd, w_pop;
    logic [2:0]      w_occ;
    logic [2*CW-1:0] w_rd_addr;
    logic [DW+1:0]   w_head;

    assign w_start = (r_state == IDLE) && bus.start;
    assign w_wr    = (r_state == LOAD) && bus.s_valid;
    assign w_pop   = (r_cnt != 2'd0) && bus.m_ready;
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign w_occ   = {1'b0, r_cnt} + {2'b0, r_infl} - {2'b0, w_pop};
    assign w_rd    = (r_state == DRAIN) && r_rd_pend && (w_occ < 3'd2);
    assign w_unused_ld_sol = w_ld_sol;

    xy_scan #(.N(N), .CW(CW)) u_load_scan (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_adv  (w_wr),
        .o_x    (w_lx),
        .o_y    (w_ly),
        .o_sol  (w_ld_sol),
        .o_last (w_ld_last)
    );

    xy_scan #(.N(N), .CW(CW)) u_drain_scan (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_adv  (w_rd),
        .o_x    (w_dx),
        .o_y    (w_dy),
        .o_sol  (w_dr_sol),
        .o_last (w_dr_last)
    );

    always_comb begin
        w_rd_addr = '0;
        case (r_op)
            OP_ID:   w_rd_addr = {w_dy, w_dx};
            OP_CCW:  w_rd_addr = {w_dx, ~w_dy};
            OP_CW:   w_rd_addr = {~w_dx, w_dy};
            OP_R180: w_rd_addr = {~w_dy, ~w_dx};
            default: w_rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_ID;
            r_rd_pend  <= 1'b0;
            r_infl     <= 1'b0;
            r_inf_sol  <= 1'b0;
            r_inf_last <= 1'b0;
            r_done     <= 1'b0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) r_fifo[i] <= '0;
        end else begin
            r_done <= 1'b0;
            r_infl <= w_rd;
            if (w_rd) begin
                r_inf_sol  <= w_dr_sol;
                r_inf_last <= w_dr_last;
                if (w_dr_last) r_rd_pend <= 1'b0;
            end
            if (r_infl) begin
                r_fifo[r_wp] <= {r_inf_sol, r_inf_last, bus.sram_rdata};
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};

            case (r_state)
                IDLE: if (w_start) begin
                    r_op    <= op_t'(bus.op);
                    r_state <= LOAD;
                end
                LOAD: if (w_wr && w_ld_last) begin
                    r_rd_pend <= 1'b1;
                    r_state   <= DRAIN;
                end
                DRAIN: if (w_pop && w_head[DW]) begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_head = r_fifo[r_rp];

    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.s_ready    = (r_state == LOAD);
    assign bus.m_valid    = (r_cnt != 2'd0);
    assign bus.m_data     = w_head[DW-1:0];
    assign bus.m_last     = w_head[DW];
    assign bus.m_sol      = w_head[DW+1];
    assign bus.sram_en    = w_wr || w_rd;
    assign bus.sram_we    = w_wr;
    assign bus.sram_addr  = w_wr ? {w_ly, w_lx} : (w_rd ? w_rd_addr : '0);
    assign bus.sram_wdata = w_wr ? bus.s_data : '0;
endmodule

// File: tb/tb_frame_rotate_ctrl.sv
// Bench for frame_rotate_ctrl at N=4: random frames through an SRAM model,
// outputs checked against an image-rotation reference each cycle.
module tb_frame_rotate_ctrl;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int DW = 8;
    localparam int NP = N * N;

    typedef struct {
        logic [DW-1:0] d;
        logic          sol;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_rotate_ctrl_if #(.CW(CW), .DW(DW)) bus();
    frame_rotate_ctrl #(.N(N), .CW(CW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [NP];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, acc_cnt = 0, issued = 0, popped = 0;
    int first_acc = -1, last_acc = -1, drain_cyc = 0, ready_pct = 100;
    bit exp_done = 1'b0, prev_stall = 1'b0;
    logic [DW+1:0] prev_word;
    exp_t exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] pix [NP];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: output pixel (y,x) of the frame rotated by orientation o.
    function automatic logic [DW-1:0] ref_pix(input logic [1:0] o, input int y, input int x);
        int r, c;
        case (o)
            2'd0:    begin r = y;         c = x;         end
            2'd1:    begin r = x;         c = N - 1 - y; end
            2'd2:    begin r = N - 1 - x; c = y;         end
            default: begin r = N - 1 - y; c = N - 1 - x; end
        endcase
        return pix[r * N + c];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Compare process: checks every cycle outside reset.
    initial forever begin
        bit hs;
        @(negedge clk);
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            hs = bus.m_valid && bus.m_ready;
            chk("done", bus.done, exp_done);
            if (exp_done) chk("busy_after_done", bus.busy, 0);
            if (bus.done) done_cnt++;
            if (!bus.sram_en) chk("idle_sram_bus", {bus.sram_addr, bus.sram_wdata}, 0);
            if (bus.busy) chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (prev_stall) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_stable", {bus.m_sol, bus.m_last, bus.m_data}, prev_word);
            end
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.m_data);
                end else begin
                    chk("m_data", bus.m_data, exp_q[0].d);
                    chk("m_sol",  bus.m_sol,  exp_q[0].sol);
                    chk("m_last", bus.m_last, exp_q[0].last);
                    if (hs) begin
                        void'(exp_q.pop_front());
                        out_log.push_back(bus.m_data);
                        acc_cnt++;
                        if (first_acc < 0) first_acc = cyc;
                        last_acc = cyc;
                    end
                end
            end
            exp_done = hs && bus.m_last;
            if (bus.sram_en && !bus.sram_we) issued++;
            if (hs) popped++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_word  = {bus.m_sol, bus.m_last, bus.m_data};
        end
    end

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_ctl"}, {bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_sol,
                           bus.m_last, bus.sram_en, bus.sram_we}, 0);
        chk({nm, "_data"}, {bus.m_data, bus.sram_addr, bus.sram_wdata}, 0);
    endtask

    task automatic run_frame(input logic [1:0] fop, input bit seq, input int gap_pct,
                             input int rpct, input int rst_after, input bit disturb);
        int i, t, d0;
        bit hs;
        for (int k = 0; k < NP; k++) pix[k] = seq ? DW'(k) : DW'($urandom);
        ready_pct = rpct;
        out_log.delete();
        acc_cnt   = 0;
        first_acc = -1;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                exp_q.push_back('{ref_pix(fop, y, x), x == 0, (y == N - 1) && (x == N - 1)});
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.op    = fop;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        i = 0;
        t = 0;
        while (i < NP && t < 400) begin
            bus.s_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.s_data  = bus.s_valid ? pix[i] : DW'($urandom);
            if (disturb) begin
                bus.op    = 2'($urandom);
                bus.start = (i == 5);
            end
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            t++;
            if (hs) i++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        drain_cyc   = cyc;
        chk("load_complete", i, NP);
        t = 0;
        while (done_cnt == d0 && t < 400) begin
            if (rst_after >= 0 && acc_cnt >= rst_after) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("rst_mid_frame");
                @(posedge clk);
                @(posedge clk);
                exp_q.delete();
                issued = 0;
                popped = 0;
                #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    logic [DW-1:0] ccw_seq [NP] = '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12};
    logic [DW-1:0] cw_row0 [N]  = '{12, 8, 4, 0};

    initial begin
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(2'd0, 1'b1, 0, 100, -1, 1'b0);
        chk("first_out_latency", first_acc - drain_cyc, 2);
        chk("full_rate_span", last_acc - first_acc, NP - 1);
        chk("id_count", out_log.size(), NP);
        for (int k = 0; k < NP && k < out_log.size(); k++) chk("id_seq", out_log[k], k);

        run_frame(2'd1, 1'b1, 0, 100, -1, 1'b0);
        chk("ccw_count", out_log.size(), NP);
        for (int k = 0; k < NP && k < out_log.size(); k++) chk("ccw_seq", out_log[k], ccw_seq[k]);

        run_frame(2'd2, 1'b1, 0, 100, -1, 1'b0);
        chk("cw_count", out_log.size(), NP);
        for (int k = 0; k < N && k < out_log.size(); k++) chk("cw_row0", out_log[k], cw_row0[k]);

        run_frame(2'd3, 1'b1, 0, 100, -1, 1'b0);
        chk("r180_count", out_log.size(), NP);
        for (int k = 0; k < NP && k < out_log.size(); k++) chk("r180_seq", out_log[k], NP - 1 - k);

        for (int f = 0; f < 4; f++) begin
            run_frame(2'($urandom), 1'b0, 30, 50, -1, 1'b1);
            chk("rand_count", out_log.size(), NP);
        end

        run_frame(2'($urandom), 1'b0, 20, 50, 5, 1'b1);
        chk("rst_frame_partial", out_log.size(), 5);
        run_frame(2'($urandom), 1'b0, 20, 50, -1, 1'b0);
        chk("post_rst_count", out_log.size(), NP);
        run_frame(2'd1, 1'b0, 0, 100, -1, 1'b0);
        chk("b2b_count", out_log.size(), NP);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
